// File: rtl/decoder_monitor.sv
// decoder_monitor: self-check stage for a registered N-way one-hot decoder.
// Re-encodes each enabled sample, classifies zero-hot / multi-hot words,
// keeps a saturating error count and a coverage bitmap of valid codes seen.
module decoder_monitor #(
    parameter int N   = 32,
    parameter int CW  = 5,
    parameter int ECW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [N-1:0]  Z,
    output logic [CW-1:0] code,
    output logic          code_valid,
    output logic          err_zero,
    output logic          err_multi,
    output logic          err_sticky,
    output logic [ECW-1:0] err_count,
    output logic [N-1:0]  seen,
    output logic          cov_done,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [N-1:0]   ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [ECW-1:0] CNT_MAX = {ECW{1'b1}};
    localparam logic [ECW-1:0] CNT_ONE = {{(ECW-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_state_next;

    logic [CW-1:0]  r_code;
    logic           r_code_valid;
    logic           r_err_zero;
    logic           r_err_multi;
    logic           r_err_sticky;
    logic [ECW-1:0] r_err_count;
    logic [N-1:0]   r_seen;

    logic           w_sample;
    logic           w_nonzero;
    logic           w_single;
    logic           w_multi;
    logic [CW-1:0]  w_low;
    logic [N-1:0]   w_seen_next;
    logic           w_full_next;
    logic           w_busy;
    logic           w_cov_done;

    // A clear in the same cycle wins over the sample, so the sample is dropped
    assign w_sample  = en & ~clr;
    assign w_nonzero = |Z;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
    assign w_single  = w_nonzero && ((Z & (Z - ONE_N)) == '0);
    assign w_multi   = w_nonzero & ~w_single;

    // Index of the lowest set bit (0 when Z is zero); scan high to low so the lowest wins
    always_comb begin
        w_low = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (Z[i]) w_low = CW'(i);
        end
    end

    // Coverage bitmap after this edge if no clear intervenes; only valid samples mark it
    always_comb begin
        w_seen_next = r_seen;
        if (w_sample && w_single) w_seen_next[w_low] = 1'b1;
    end

    assign w_full_next = &w_seen_next;

    // Per-sample registers: code, classification flags, coverage and error statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_err_zero   <= 1'b0;
            r_err_multi  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
            r_seen       <= '0;
        end else if (clr) begin
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_err_zero   <= 1'b0;
            r_err_multi  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
            r_seen       <= '0;
        end else if (en) begin
            r_code       <= w_low;
            r_code_valid <= w_single;
            r_err_zero   <= ~w_nonzero;
            r_err_multi  <= w_multi;
            r_seen       <= w_seen_next;
            if (!w_single) begin
                r_err_sticky <= 1'b1;
                if (r_err_count != CNT_MAX) r_err_count <= r_err_count + CNT_ONE;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next state: start on first sample, finish when coverage completes, clr restarts
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sample) w_state_next = w_full_next ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (clr)              w_state_next = S_IDLE;
                else if (w_full_next) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (clr) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: busy while collecting coverage, done once all codes observed
    always_comb begin
        w_busy     = 1'b0;
        w_cov_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy     = 1'b1;
            S_DONE:  w_cov_done = 1'b1;
            default: ;
        endcase
    end

    assign code       = r_code;
    assign code_valid = r_code_valid;
    assign err_zero   = r_err_zero;
    assign err_multi  = r_err_multi;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;
    assign seen       = r_seen;
    assign cov_done   = w_cov_done;
    assign busy       = w_busy;

endmodule

// File: doc/decoder_monitor.md
Name: decoder_monitor

Overview:
- Downstream consumer of the registered 5-to-32 one-hot decoder output.
- Samples the 32-bit word each enabled cycle and re-encodes it to a 5-bit code.
- Flags zero-hot and multi-hot words, keeps a saturating error count, and records a coverage bitmap of the codes seen.
- Reports when all 32 codes have been observed. It is used on-chip and in bench as the decoder's self-check stage.

Parameters:
- N, 32, one-hot input width; must be a power of 2.
- CW, 5, code width, equal to log2(N).
- ECW, 8, error counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample Z this cycle.
- clr  input  1  synchronous statistics clear.
- Z  input  N  one-hot word from the decoder (already registered upstream).
- code  output  CW  encoded index of the last sample.
- code_valid  output  1  last sample was exactly one-hot.
- err_zero  output  1  last sample had no bit set.
- err_multi  output  1  last sample had 2 or more bits set.
- err_sticky  output  1  any error since the last rst or clr.
- err_count  output  ECW  number of errored samples, saturating.
- seen  output  N  bit i set once a valid code i has been observed.
- cov_done  output  1  seen is all ones.
- busy  output  1  FSM is in state RUN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs go to 0: code=0, code_valid=0, err_zero=0, err_multi=0, err_sticky=0, err_count=0, seen=0, cov_done=0, busy=0.
  - FSM goes to IDLE.
  - rst overrides clr and en.
- Latency: Z sampled at edge k with en=1 gives code, code_valid, err_zero and err_multi valid after edge k. seen, err_count and cov_done reflect that sample after the same edge.
- en=0:
  - code, code_valid, err_zero, err_multi, seen and err_count hold.
  - No per-sample pulse is generated; flags stay at their last value.
- Encode rule:
  - popcount(Z)==1: code=index of the set bit, code_valid=1, err_zero=0, err_multi=0.
  - Z==0: code=0, code_valid=0, err_zero=1.
  - popcount(Z)>=2: code=index of the lowest set bit, code_valid=0, err_multi=1.
  - err_zero and err_multi are mutually exclusive.
- Coverage:
  - On a valid sample, seen[code] is set to 1 and never clears except by rst or clr.
  - Errored samples never modify seen.
- Errors:
  - Each errored sample increments err_count by 1, saturating at 2^ECW-1 (255 by default); no wrap.
  - err_sticky is set on the first errored sample.
- clr=1 (with rst=0):
  - seen, err_count, err_sticky, cov_done, code_valid, err_zero and err_multi are cleared; code is set to 0; FSM goes to IDLE.
  - A sample presented in the same cycle (en=1) is discarded.
- FSM:
  - IDLE: busy=0. The first en=1 cycle processes that sample and moves to RUN.
  - RUN: busy=1. Moves to DONE after the edge where seen becomes all ones; cov_done=1 from that edge onward.
  - DONE: busy=0, cov_done=1. Sampling, error detection and counting continue; seen stays all ones. Exits only on rst or clr.
  - If a single sample completes coverage from IDLE (only possible for N=1), the FSM goes directly to DONE.
- Repeated codes are legal and set no error.
- Implementation is purely synchronous; no combinational path from Z to any output.

Test Plan:
- Reset: assert rst 2 cycles with Z=0xFFFFFFFF and en=1 -> every output is 0 and busy=0 on the cycle after rst falls (en still low).
- Full sweep: en=1, Z=1<<i for i=0..31 on consecutive cycles.
  - After each edge, code=i and code_valid=1.
  - busy=1 from edge 1.
  - cov_done=1 and busy=0 exactly after edge 32; seen=0xFFFFFFFF; err_count=0.
- Error classes:
  - Z=0x00000000 -> err_zero=1, code_valid=0, err_count=1, err_sticky=1.
  - Then Z=0x00000005 -> err_multi=1, code=0, err_count=2, seen unchanged.
- Saturation: 300 consecutive samples with Z=0 -> err_count=255 and it holds at 255; err_sticky=1.
- clr priority: after 10 valid codes, pulse clr with en=1 and Z=0x80000000 -> seen=0, err_count=0, FSM IDLE, and seen[31] remains 0 on the next cycle.
- Hold with en=0: after code=7, drive en=0 with Z=0 for 5 cycles -> code=7 and code_valid=1 held, err_count unchanged.
